// File: rtl/sync_fifo_level.sv
// sync_fifo_level
// Single-clock FIFO with fill-level reporting, programmable almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and a synchronous
// flush. Pointers are plain binary because producer and consumer share CLK.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   defined   : first-word-fall-through, R_DATA shows the head word directly
//   undefined : registered read, R_DATA/R_VALID one cycle after an accepted read
//
// Ports:
//   CLK, RST            clock (rising edge), async active-low reset
//   CLR                 synchronous flush (pointers, level, error flags)
//   WR_INC, WR_DATA     write request and data
//   WR_FULL             FIFO holds 2^AWL words
//   R_INC               read request (pop in FWFT mode)
//   R_DATA, R_VALID     read data and its qualifier
//   R_EMPTY             FIFO holds 0 words
//   LEVEL               word count 0..2^AWL
//   ALMOST_FULL/EMPTY   LEVEL >= AF_LVL / LEVEL <= AE_LVL
//   OVERFLOW/UNDERFLOW  sticky write-while-full / read-while-empty
module sync_fifo_level #(
   parameter int unsigned DWL    = 16,
   parameter int unsigned AWL    = 8,
   parameter int unsigned AF_LVL = (2 ** AWL) - 2,
   parameter int unsigned AE_LVL = 2
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           CLR,
   input  logic           WR_INC,
   input  logic [DWL-1:0] WR_DATA,
   output logic           WR_FULL,
   input  logic           R_INC,
   output logic [DWL-1:0] R_DATA,
   output logic           R_VALID,
   output logic           R_EMPTY,
   output logic [AWL:0]   LEVEL,
   output logic           ALMOST_FULL,
   output logic           ALMOST_EMPTY,
   output logic           OVERFLOW,
   output logic           UNDERFLOW
);

   localparam int unsigned DEPTH = 2 ** AWL;
   localparam int unsigned LW    = AWL + 1;

   logic [DWL-1:0] mem [DEPTH];

   logic [AWL-1:0] wp_q, wp_d;
   logic [AWL-1:0] rp_q, rp_d;
   logic [LW-1:0]  level_q, level_d;
   logic           full_q, full_d;
   logic           empty_q, empty_d;
   logic           af_q, af_d;
   logic           ae_q, ae_d;
   logic           ovf_q, ovf_d;
   logic           udf_q, udf_d;
   logic           we, re, mem_we;

`ifndef SYNC_FIFO_FWFT_EN
   logic [DWL-1:0] rdata_q, rdata_d;
   logic           rvalid_q, rvalid_d;
`endif

   // Accept decisions come from the registered flags, so a read frees a
   // slot only for the next cycle (full + rd + wr rejects the write).
   always_comb begin
      we      = WR_INC & ~full_q;
      re      = R_INC & ~empty_q;
      mem_we  = we & ~CLR;
      wp_d    = wp_q;
      rp_d    = rp_q;
      level_d = level_q;
      ovf_d   = ovf_q | (WR_INC & full_q);
      udf_d   = udf_q | (R_INC & empty_q);
`ifndef SYNC_FIFO_FWFT_EN
      rdata_d  = rdata_q;
      rvalid_d = re;
`endif
      if (CLR) begin
         wp_d    = '0;
         rp_d    = '0;
         level_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
         rvalid_d = 1'b0;
`endif
      end else begin
         if (we) wp_d = wp_q + AWL'(1);
         if (re) begin
            rp_d = rp_q + AWL'(1);
`ifndef SYNC_FIFO_FWFT_EN
            rdata_d = mem[rp_q];
`endif
         end
         if (we && !re)      level_d = level_q + LW'(1);
         else if (re && !we) level_d = level_q - LW'(1);
      end
      // Status flags track the next level so they agree with LEVEL.
      full_d  = (level_d == LW'(DEPTH));
      empty_d = (level_d == '0);
      af_d    = (level_d >= LW'(AF_LVL));
      ae_d    = (level_d <= LW'(AE_LVL));
   end

   // Storage array is not reset; emptiness is tracked by the level only.
   always_ff @(posedge CLK) begin
      if (mem_we) mem[wp_q] <= WR_DATA;
   end

   // Control and status state.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         level_q <= level_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         af_q    <= af_d;
         ae_q    <= ae_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word falls through; forced to zero when empty so reset and flush
   // give a defined output without clearing the array.
   assign R_DATA  = empty_q ? '0 : mem[rp_q];
   assign R_VALID = ~empty_q;
`else
   // Registered read port.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign R_DATA  = rdata_q;
   assign R_VALID = rvalid_q;
`endif

   assign WR_FULL      = full_q;
   assign R_EMPTY      = empty_q;
   assign LEVEL        = level_q;
   assign ALMOST_FULL  = af_q;
   assign ALMOST_EMPTY = ae_q;
   assign OVERFLOW     = ovf_q;
   assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_sync_fifo_level.sv
// Testbench for sync_fifo_level (DWL=16, AWL=3, AF_LVL=6, AE_LVL=1).
// Reference: a word queue plus sticky flags, updated once per clock edge.
module tb_sync_fifo_level;

   localparam int unsigned DWL = 16;
   localparam int unsigned AWL = 3;
   localparam int unsigned DEP = 8;

   logic           CLK = 1'b0;
   logic           RST = 1'b0;
   logic           CLR = 1'b0;
   logic           WR_INC = 1'b0;
   logic [DWL-1:0] WR_DATA = '0;
   logic           R_INC = 1'b0;
   logic           WR_FULL, R_VALID, R_EMPTY;
   logic           ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
   logic [DWL-1:0] R_DATA;
   logic [AWL:0]   LEVEL;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [DWL-1:0] q[$];
   logic           m_ovf = 1'b0;
   logic           m_udf = 1'b0;
   logic           m_rvalid = 1'b0;
   logic [DWL-1:0] m_rdata = '0;

   sync_fifo_level #(.DWL(DWL), .AWL(AWL), .AF_LVL(6), .AE_LVL(1)) dut (
      .CLK(CLK), .RST(RST), .CLR(CLR),
      .WR_INC(WR_INC), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL),
      .R_INC(R_INC), .R_DATA(R_DATA), .R_VALID(R_VALID), .R_EMPTY(R_EMPTY),
      .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rvalid = 1'b0;
      m_rdata = '0;
   endtask

   // One clock edge of FIFO behaviour, from the inputs sampled at that edge.
   task automatic model_edge(input logic wr, input logic [DWL-1:0] wd,
                             input logic rd, input logic clr);
      bit full, empty;
      full  = (q.size() == DEP);
      empty = (q.size() == 0);
      if (clr) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_rvalid = 1'b0;
      end else begin
         if (wr && full) m_ovf = 1'b1;
         if (rd && empty) m_udf = 1'b1;
         m_rvalid = 1'b0;
         if (rd && !empty) begin
            m_rdata = q.pop_front();
            m_rvalid = 1'b1;
         end
         if (wr && !full) q.push_back(wd);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".level"},  32'(LEVEL), 32'(n));
      chk({tag, ".full"},   32'(WR_FULL), 32'(n == DEP));
      chk({tag, ".empty"},  32'(R_EMPTY), 32'(n == 0));
      chk({tag, ".af"},     32'(ALMOST_FULL), 32'(n >= 6));
      chk({tag, ".ae"},     32'(ALMOST_EMPTY), 32'(n <= 1));
      chk({tag, ".ovf"},    32'(OVERFLOW), 32'(m_ovf));
      chk({tag, ".udf"},    32'(UNDERFLOW), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
      chk({tag, ".rvalid"}, 32'(R_VALID), 32'(n != 0));
      chk({tag, ".rdata"},  32'(R_DATA), (n != 0) ? 32'(q[0]) : 32'd0);
`else
      chk({tag, ".rvalid"}, 32'(R_VALID), 32'(m_rvalid));
      chk({tag, ".rdata"},  32'(R_DATA), 32'(m_rdata));
`endif
   endtask

   // Called 1 time unit after a rising edge; drives, clocks, then checks.
   task automatic step(input string tag, input logic wr, input logic [DWL-1:0] wd,
                       input logic rd, input logic clr);
      WR_INC  = wr;
      WR_DATA = wd;
      R_INC   = rd;
      CLR     = clr;
      @(posedge CLK);
      model_edge(wr, wd, rd, clr);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      WR_INC = 1'b0; R_INC = 1'b0; CLR = 1'b0;
      RST = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      check_all("reset");
      RST = 1'b1;
   endtask

   initial begin
      logic [DWL-1:0] d;

      // Reset state
      @(posedge CLK);
      #1;
      do_reset();

      // 1: fill with 1..8
      for (int i = 1; i <= 8; i++) step("fill", 1'b1, DWL'(i), 1'b0, 1'b0);
      chk("fill.level8", 32'(LEVEL), 32'd8);

      // 2: overflow write, then drain in order
      step("ovf", 1'b1, 16'hDEAD, 1'b0, 1'b0);
      chk("ovf.flag", 32'(OVERFLOW), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         step("drain", 1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
         chk("drain.word", 32'(R_DATA), 32'(i));
`endif
      end
      step("idle", 1'b0, '0, 1'b0, 1'b0);
      chk("ovf.sticky", 32'(OVERFLOW), 32'd1);

      // 3: underflow after reset, cleared by CLR
      do_reset();
      step("udf", 1'b0, '0, 1'b1, 1'b0);
      chk("udf.flag", 32'(UNDERFLOW), 32'd1);
      step("udf_clr", 1'b0, '0, 1'b0, 1'b1);

      // 4: steady level 4 with simultaneous traffic across the wrap
      d = 16'h0100;
      for (int i = 0; i < 4; i++) begin step("pre4", 1'b1, d, 1'b0, 1'b0); d++; end
      for (int i = 0; i < 20; i++) begin step("rw4", 1'b1, d, 1'b1, 1'b0); d++; end
      chk("rw4.level", 32'(LEVEL), 32'd4);
      for (int i = 0; i < 4; i++) begin step("top", 1'b1, d, 1'b0, 1'b0); d++; end
      step("rw_full", 1'b1, d, 1'b1, 1'b0);
      d++;
      chk("rw_full.level7", 32'(LEVEL), 32'd7);
      chk("rw_full.ovf", 32'(OVERFLOW), 32'd1);

      // 5: CLR with a write at level 5
      step("dn", 1'b0, '0, 1'b1, 1'b0);
      step("dn", 1'b0, '0, 1'b1, 1'b0);
      chk("pre_clr.level5", 32'(LEVEL), 32'd5);
      step("clr_wr", 1'b1, 16'hBEEF, 1'b0, 1'b1);
      chk("clr_wr.level0", 32'(LEVEL), 32'd0);
      step("clr_idle", 1'b0, '0, 1'b0, 1'b0);

      // Randomised traffic against the reference
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 1)), DWL'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));

      // 6: single word into empty FIFO, then pop
      step("a5_clr", 1'b0, '0, 1'b0, 1'b1);
      step("a5_wr", 1'b1, 16'h00A5, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
      chk("a5.fwft_data", 32'(R_DATA), 32'h00A5);
      chk("a5.fwft_valid", 32'(R_VALID), 32'd1);
`endif
      step("a5_pop", 1'b0, '0, 1'b1, 1'b0);
      chk("a5.empty", 32'(R_EMPTY), 32'd1);

      // Asynchronous reset mid-stream, checked between clock edges
      for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, DWL'(16'h0700 + i), 1'b1, 1'b0);
      step("pre_rst", 1'b1, 16'h0777, 1'b0, 1'b0);
      WR_INC = 1'b0; R_INC = 1'b0;
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(posedge CLK);
      #1;
      check_all("async_rst_hold");
      RST = 1'b1;
      step("post_rst", 1'b1, 16'h0042, 1'b0, 1'b0);
      step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
